// File: rtl/sevseg_mux_n.sv
// N-digit multiplexed seven-segment driver: double-buffered digit bank, PWM dimming, anti-ghost guard.
// Optional per-digit blink enabled by defining SEVSEG_BLINK_EN.
module sevseg_mux_n #(
    parameter int NUM_DIGITS     = 2,
    parameter int SLOT_CYCLES    = 12000,
    parameter int GUARD_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0,
    localparam int AW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [AW-1:0]         WR_ADDR,
    input  logic                  WR_HEX,
    input  logic [7:0]            WR_DATA,
    input  logic                  COMMIT,
    input  logic [3:0]            BRIGHT,
`ifdef SEVSEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0] BLINK,
`endif
    output logic                  PENDING,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] DIG
);

    localparam int SCW = $clog2(SLOT_CYCLES);

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [7:0]            shadow  [NUM_DIGITS];
    logic [7:0]            display [NUM_DIGITS];
    logic [SCW-1:0]        slot_cnt;
    logic [AW-1:0]         idx;
    logic [3:0]            pwm_cnt;
    logic                  pending;
    logic [7:0]            byte_q;
    logic [NUM_DIGITS-1:0] dig_q;

    logic                  slot_wrap;
    logic                  idx_last;
    logic                  addr_ok;
    logic                  lit;
    logic                  blank;
    logic [7:0]            wr_byte;
    logic [7:0]            byte_nxt;
    logic [NUM_DIGITS-1:0] dig_nxt;

    assign slot_wrap = (slot_cnt == SCW'(SLOT_CYCLES - 1));
    assign idx_last  = (idx == AW'(NUM_DIGITS - 1));
    assign addr_ok   = (32'(WR_ADDR) < NUM_DIGITS);
    assign lit       = (BRIGHT == 4'hF) || (pwm_cnt < BRIGHT);
    assign wr_byte   = WR_HEX ? {WR_DATA[7], hex7(WR_DATA[3:0])} : WR_DATA;

`ifdef SEVSEG_BLINK_EN
    logic [7:0] scan_cnt;
    logic       blink_phase;

    // Phase flips once every 256 complete scans of all digits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt    <= '0;
            blink_phase <= 1'b0;
        end else if (slot_wrap && idx_last) begin
            scan_cnt <= scan_cnt + 8'd1;
            if (scan_cnt == 8'hFF)
                blink_phase <= ~blink_phase;
        end
    end

    assign blank = blink_phase && BLINK[idx];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        dig_nxt  = '0;
        byte_nxt = '0;
        if (slot_cnt >= SCW'(GUARD_CYCLES)) begin
            dig_nxt = NUM_DIGITS'(1) << idx;
            if (lit && !blank)
                byte_nxt = display[idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_cnt <= '0;
            idx      <= '0;
            pwm_cnt  <= '0;
            pending  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i]  <= '0;
                display[i] <= '0;
            end
            byte_q <= {8{SEG_ACTIVE_LOW}};
            dig_q  <= {NUM_DIGITS{SEL_ACTIVE_LOW}};
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;

            if (slot_wrap) begin
                slot_cnt <= '0;
                idx      <= idx_last ? '0 : idx + AW'(1);
            end else begin
                slot_cnt <= slot_cnt + SCW'(1);
            end

            if (WR_EN && addr_ok)
                shadow[WR_ADDR] <= wr_byte;

            // The copy takes the shadow as it was before this edge, so a same-edge write waits for the next commit.
            if (slot_wrap && (pending || COMMIT)) begin
                display <= shadow;
                pending <= 1'b0;
            end else if (COMMIT) begin
                pending <= 1'b1;
            end

            byte_q <= byte_nxt ^ {8{SEG_ACTIVE_LOW}};
            dig_q  <= dig_nxt ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};
        end
    end

    assign PENDING = pending;
    assign SEG     = byte_q[6:0];
    assign DP      = byte_q[7];
    assign DIG     = dig_q;

endmodule
